prog_loader: RTL and testbench

Upstream bitstream loader for the GrainFlex fabric's serial programming interface. It accepts configuration bytes over a valid/ready stream and drives prog_clk / prog_rst / prog_en / prog_din at a programmable rate derived from the system clock. It also captures the bits that leave the configuration chain on prog_dout and returns them as readback bytes. It sits between the host-side byte source and the fabric's io_progIface_* pins, replacing manual bit-banging of those pins.

---
 rtl/prog_loader.sv | 207 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream to serial programming-chain loader for the
// GrainFlex fabric, with readback of the bits leaving the chain.
module prog_loader #(
    parameter int CHAIN_BITS = 256,
    parameter int DIV        = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       busy,
    output logic       done,
    output logic       prog_clk,
    output logic       prog_rst,
    output logic       prog_en,
    output logic       prog_din,
    input  logic       prog_dout
);

    localparam int BW = $clog2(CHAIN_BITS + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_BITS - 1);
    localparam logic [DW-1:0] DIV_LD   = DW'(DIV - 1);
    localparam logic [RW-1:0] RST_LD   = RW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    rb_q, rb_d;
    logic [7:0]    samp;
    logic          s_ready_q, s_ready_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          prog_clk_q, prog_clk_d;
    logic          prog_rst_q, prog_rst_d;
    logic          prog_en_q, prog_en_d;
    logic          prog_din_q, prog_din_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        div_cnt_d  = div_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        byte_d     = byte_q;
        rb_d       = rb_q;
        s_ready_d  = s_ready_q;
        m_data_d   = m_data_q;
        m_valid_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        prog_clk_d = prog_clk_q;
        prog_rst_d = prog_rst_q;
        prog_en_d  = prog_en_q;
        prog_din_d = prog_din_q;
        // rb_q is cleared at each byte start, so unset high bits stay zero
        samp        = rb_q;
        samp[idx_q] = prog_dout;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RST;
                    busy_d     = 1'b1;
                    prog_rst_d = 1'b1;
                    rst_cnt_d  = RST_LD;
                end
            end
            RST: begin
                if (rst_cnt_q == '0) begin
                    state_d    = LOAD;
                    prog_rst_d = 1'b0;
                    prog_en_d  = 1'b1;
                    s_ready_d  = 1'b1;
                    bit_cnt_d  = '0;
                    idx_d      = '0;
                    rb_d       = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q - RW'(1);
                end
            end
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    state_d    = SHIFT_LO;
                    byte_d     = s_data;
                    s_ready_d  = 1'b0;
                    prog_din_d = s_data[0];
                    idx_d      = '0;
                    div_cnt_d  = DIV_LD;
                end
            end
            SHIFT_LO: begin
                if (div_cnt_q == '0) begin
                    state_d    = SHIFT_HI;
                    prog_clk_d = 1'b1;
                    div_cnt_d  = DIV_LD;
                    rb_d       = samp;
                    if (idx_q == 3'd7 || bit_cnt_q == LAST_BIT) begin
                        m_data_d  = samp;
                        m_valid_d = 1'b1;
                        rb_d      = '0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_cnt_q == '0) begin
                    prog_clk_d = 1'b0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = FINISH;
                        prog_en_d  = 1'b0;
                        prog_din_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (idx_q == 3'd7) begin
                            state_d   = LOAD;
                            s_ready_d = 1'b1;
                        end else begin
                            state_d    = SHIFT_LO;
                            idx_d      = idx_q + 3'd1;
                            prog_din_d = byte_q[idx_q+3'd1];
                            div_cnt_d  = DIV_LD;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q - DW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            div_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            byte_q     <= '0;
            rb_q       <= '0;
            s_ready_q  <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prog_clk_q <= 1'b0;
            prog_rst_q <= 1'b0;
            prog_en_q  <= 1'b0;
            prog_din_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            div_cnt_q  <= div_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            byte_q     <= byte_d;
            rb_q       <= rb_d;
            s_ready_q  <= s_ready_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            prog_clk_q <= prog_clk_d;
            prog_rst_q <= prog_rst_d;
            prog_en_q  <= prog_en_d;
            prog_din_q <= prog_din_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign prog_clk = prog_clk_q;
    assign prog_rst = prog_rst_q;
    assign prog_en  = prog_en_q;
    assign prog_din = prog_din_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a 16-bit chain instance (DIV=2) and a
// 12-bit partial-byte instance (DIV=1), each with a chain model on prog_clk.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- 16-bit instance ----------------
    logic       st16 = 0, sv16 = 0, sr16, mv16, busy16, done16;
    logic       pclk16, prst16, pen16, pdin16, pdout16;
    logic [7:0] sd16 = 0, md16;
    logic [15:0] chain16 = 16'hBEEF;

    prog_loader #(.CHAIN_BITS(16), .DIV(2), .RST_CYCLES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .s_data(sd16),
        .s_valid(sv16), .s_ready(sr16), .m_data(md16), .m_valid(mv16),
        .busy(busy16), .done(done16), .prog_clk(pclk16),
        .prog_rst(prst16), .prog_en(pen16), .prog_din(pdin16),
        .prog_dout(pdout16)
    );

    always @(posedge pclk16) chain16 <= {pdin16, chain16[15:1]};
    assign pdout16 = chain16[0];

    // ---------------- 12-bit instance ----------------
    logic       st12 = 0, sv12 = 0, sr12, mv12, busy12, done12;
    logic       pclk12, prst12, pen12, pdin12, pdout12;
    logic [7:0] sd12 = 0, md12;
    logic [11:0] chain12 = 12'hFFF;

    prog_loader #(.CHAIN_BITS(12), .DIV(1), .RST_CYCLES(2)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(st12), .s_data(sd12),
        .s_valid(sv12), .s_ready(sr12), .m_data(md12), .m_valid(mv12),
        .busy(busy12), .done(done12), .prog_clk(pclk12),
        .prog_rst(prst12), .prog_en(pen12), .prog_din(pdin12),
        .prog_dout(pdout12)
    );

    always @(posedge pclk12) chain12 <= {pdin12, chain12[11:1]};
    assign pdout12 = chain12[0];

    // ---------------- scoreboards and monitors ----------------
    logic q_din16[$];
    logic [7:0] q_rb16[$];
    logic q_din12[$];
    logic [7:0] q_rb12[$];
    bit rb_en16 = 1'b1;

    int cyc = 0;
    int rises16 = 0, dones16 = 0, prst_cyc16 = 0, spc16 = 0, mvs16 = 0;
    int last16 = 0;
    logic prev16 = 1'b0;
    int rises12 = 0, dones12 = 0, prst_cyc12 = 0, spc12 = 0, mvs12 = 0;
    int last12 = 0;
    logic prev12 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (pclk16 === 1'b1 && prev16 === 1'b0) begin
            rises16++;
            check("din16_expected_bit_available", q_din16.size() != 0, 1);
            if (q_din16.size() != 0)
                check($sformatf("din16_rise%0d", rises16), pdin16,
                      q_din16.pop_front());
            if ((rises16 % 8) != 1 && cyc - last16 != 4) spc16++;
            last16 = cyc;
        end
        prev16 = pclk16;
        if (mv16 === 1'b1) begin
            mvs16++;
            if (rb_en16) begin
                check("rb16_expected_available", q_rb16.size() != 0, 1);
                if (q_rb16.size() != 0)
                    check("rb16_data", md16, q_rb16.pop_front());
            end
        end
        if (done16 === 1'b1) dones16++;
        if (prst16 === 1'b1) prst_cyc16++;
    end

    always @(negedge clk) begin
        if (pclk12 === 1'b1 && prev12 === 1'b0) begin
            rises12++;
            check("din12_expected_bit_available", q_din12.size() != 0, 1);
            if (q_din12.size() != 0)
                check($sformatf("din12_rise%0d", rises12), pdin12,
                      q_din12.pop_front());
            if ((rises12 % 8) != 1 && cyc - last12 != 2) spc12++;
            last12 = cyc;
        end
        prev12 = pclk12;
        if (mv12 === 1'b1) begin
            mvs12++;
            check("rb12_expected_available", q_rb12.size() != 0, 1);
            if (q_rb12.size() != 0)
                check("rb12_data", md12, q_rb12.pop_front());
        end
        if (done12 === 1'b1) dones12++;
        if (prst12 === 1'b1) prst_cyc12++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] outs16();
        return {sr16, md16, mv16, busy16, done16, pclk16, prst16, pen16,
                pdin16};
    endfunction

    task automatic push16(input logic [7:0] b);
        for (int i = 0; i < 8; i++) q_din16.push_back(b[i]);
    endtask

    task automatic clr16();
        @(posedge clk); #1;
        rises16 = 0; dones16 = 0; prst_cyc16 = 0; spc16 = 0; mvs16 = 0;
    endtask

    task automatic start16();
        @(negedge clk); st16 = 1'b1;
        @(posedge clk); #1; st16 = 1'b0;
        check("start16_busy_prog_rst", {busy16, prst16}, 2'b11);
    endtask

    task automatic send16(input logic [7:0] d);
        int n = 0;
        @(negedge clk); sd16 = d; sv16 = 1'b1;
        while (sr16 !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        check("send16_ready_seen", sr16, 1'b1);
        @(posedge clk); #1; sv16 = 1'b0;
    endtask

    task automatic wait_ready16();
        int n = 0;
        while (sr16 !== 1'b1 && n < 500) begin @(posedge clk); #1; n++; end
        check("wait_ready16", sr16, 1'b1);
    endtask

    task automatic wait_done16();
        int n = 0;
        while (done16 !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
        check("done16_seen", done16, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("busy16_clear_after_done", busy16, 1'b0);
    endtask

    task automatic reset_check(input string nm);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check(nm, outs16(), 16'h0);
        @(negedge clk); rst_n = 1'b1;
        q_din16.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int viol;
        int r0;
        int n;
        int sr_hi;
        #2 rst_n = 1'b0;
        #1 check("reset_idle_outs16", outs16(), 16'h0);
        check("reset_idle_outs12",
              {sr12, md12, mv12, busy12, done12, pclk12, prst12, pen12,
               pdin12}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Run A: basic load, readback of preloaded 0xBEEF
        clr16();
        push16(8'hA5); push16(8'h3C);
        q_rb16.push_back(8'hEF); q_rb16.push_back(8'hBE);
        start16();
        send16(8'hA5);
        send16(8'h3C);
        wait_done16();
        check("A_rises", rises16, 16);
        check("A_prst_cycles", prst_cyc16, 4);
        check("A_done_pulses", dones16, 1);
        check("A_spacing_errs", spc16, 0);
        check("A_mvalid_pulses", mvs16, 2);
        check("A_din_q_left", q_din16.size(), 0);
        check("A_rb_q_left", q_rb16.size(), 0);

        // Run B: 10-cycle gap; chain now holds 0x3CA5 from run A
        clr16();
        push16(8'hA5); push16(8'h3C);
        q_rb16.push_back(8'hA5); q_rb16.push_back(8'h3C);
        start16();
        send16(8'hA5);
        wait_ready16();
        viol = 0;
        r0 = rises16;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({pclk16, pen16, sr16} !== 3'b011) viol++;
        end
        check("B_gap_violations", viol, 0);
        check("B_gap_no_rises", rises16, r0);
        send16(8'h3C);
        wait_done16();
        check("B_rises", rises16, 16);
        check("B_done_pulses", dones16, 1);
        check("B_mvalid_pulses", mvs16, 2);
        check("B_rb_q_left", q_rb16.size(), 0);

        // Resets in each active state
        rb_en16 = 1'b0;
        start16();
        reset_check("rst_in_RST");
        start16();
        wait_ready16();
        reset_check("rst_in_LOAD");
        start16();
        send16(8'hA5);
        check("in_SHIFT_LO_pclk", pclk16, 1'b0);
        reset_check("rst_in_SHIFT_LO");

        start16();
        push16(8'hA5);
        send16(8'hA5);
        n = 0;
        while (pclk16 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        st16 = 1'b1;
        @(posedge clk); #1; st16 = 1'b0;
        check("start_busy_ignored", {busy16, prst16, pen16}, 3'b101);
        n = 0;
        while (pclk16 !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
        while (pclk16 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        check("in_SHIFT_HI_pclk", pclk16, 1'b1);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check("rst_in_SHIFT_HI_pclk_pen", {pclk16, pen16}, 2'b00);
        check("rst_in_SHIFT_HI_outs", outs16(), 16'h0);
        @(negedge clk); rst_n = 1'b1;
        q_din16.delete();

        // Reload from bit 0 after mid-run reset
        clr16();
        push16(8'h5A); push16(8'hC3);
        start16();
        send16(8'h5A);
        send16(8'hC3);
        wait_done16();
        check("R_rises", rises16, 16);
        check("R_done_pulses", dones16, 1);
        check("R_din_q_left", q_din16.size(), 0);

        // Partial final byte on the 12-bit chain
        for (int i = 0; i < 12; i++) q_din12.push_back(1'b1);
        q_rb12.push_back(8'hFF); q_rb12.push_back(8'h0F);
        @(negedge clk); st12 = 1'b1;
        @(posedge clk); #1; st12 = 1'b0;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            @(negedge clk); sd12 = 8'hFF; sv12 = 1'b1;
            while (sr12 !== 1'b1 && n < 500) begin @(negedge clk); n++; end
            check("send12_ready_seen", sr12, 1'b1);
            @(posedge clk); #1; sv12 = 1'b0;
        end
        sd12 = 8'h55; sv12 = 1'b1;
        sr_hi = 0;
        n = 0;
        while (done12 !== 1'b1 && n < 500) begin
            @(posedge clk); #1; n++;
            if (sr12 === 1'b1) sr_hi++;
        end
        check("P_done_seen", done12, 1'b1);
        repeat (10) begin
            @(posedge clk); #1;
            if (sr12 === 1'b1) sr_hi++;
        end
        sv12 = 1'b0;
        check("P_third_byte_not_accepted", sr_hi, 0);
        check("P_rises", rises12, 12);
        check("P_prst_cycles", prst_cyc12, 2);
        check("P_done_pulses", dones12, 1);
        check("P_spacing_errs", spc12, 0);
        check("P_mvalid_pulses", mvs12, 2);
        check("P_rb_q_left", q_rb12.size(), 0);
        check("P_busy_clear", busy12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
